// File: rtl/core1_pkg.sv
// Shared definitions for the Core1 datapath: operand widths, opcode values as seen on the
// core select line, the sequencer state encoding and an opcode legality helper.
package core1_pkg;

    localparam int unsigned OPW  = 256;
    localparam int unsigned HALF = 128;

    // Same select codes the Core1 arithmetic core decodes.
    localparam logic [2:0] IDLE_SEL = 3'b000;
    localparam logic [2:0] SQR      = 3'b001;
    localparam logic [2:0] XOR      = 3'b010;
    localparam logic [2:0] LUT      = 3'b011;
    localparam logic [2:0] MASK     = 3'b100;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StWait,
        StCapture,
        StResp
    } seq_state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == SQR) || (op == XOR) || (op == LUT) || (op == MASK);
    endfunction

endpackage

// File: rtl/core1_lat_counter.sv
// Loadable down-counter used to time multi-cycle cores.
//   clk, rst_n  : clock, asynchronous active-low reset (count resets to 0)
//   load_i      : load load_val_i (has priority over en_i)
//   load_val_i  : value to load
//   en_i        : decrement by one, saturating at zero
//   done_o      : the count is at or reaches zero on this edge when enabled
module core1_lat_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q <= Width'(1));

endmodule

// File: rtl/core1_op_sequencer.sv
// Command sequencer for the Core1 arithmetic core. Accepts one command at a time, drives the
// core operands/select, samples the 256-bit result after CORE_LAT cycles, optionally
// XOR-accumulates it and returns it on a valid/ready response channel.
//   cmd_*  : command channel (valid/ready), opcode, accumulate/clear flags, operands A/B
//   core_* : registered operands and select to the core, C/D result halves from the core
//   rsp_*  : response channel (valid/ready), result halves, illegal-opcode flag
//   busy   : sequencer is not idle
module core1_op_sequencer
    import core1_pkg::*;
#(
    parameter int unsigned CORE_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic            cmd_acc,
    input  logic            cmd_acc_clr,
    input  logic [OPW-1:0]  cmd_a,
    input  logic [OPW-1:0]  cmd_b,
    output logic [OPW-1:0]  core_a,
    output logic [OPW-1:0]  core_b,
    output logic [2:0]      core_sel,
    input  logic [HALF-1:0] core_c,
    input  logic [HALF-1:0] core_d,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [HALF-1:0] rsp_c,
    output logic [HALF-1:0] rsp_d,
    output logic            rsp_err,
    output logic            busy
);

    localparam int unsigned CntW = (CORE_LAT > 2) ? $clog2(CORE_LAT) : 1;

    seq_state_e     state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic           acc_q, acc_d;
    logic           clr_q, clr_d;
    logic [OPW-1:0] a_q, a_d, b_q, b_d;
    logic [OPW-1:0] core_a_q, core_a_d, core_b_q, core_b_d;
    logic [2:0]     core_sel_q, core_sel_d;
    logic [OPW-1:0] accum_q, accum_d;
    logic [OPW-1:0] rsp_q, rsp_d_n;
    logic           err_q, err_d;
    logic [OPW-1:0] cap_r, acc_base, acc_new;
    logic           cnt_load, cnt_en, cnt_done;

    core1_lat_counter #(
        .Width (CntW)
    ) u_lat_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (CntW'(CORE_LAT - 1)),
        .en_i       (cnt_en),
        .done_o     (cnt_done)
    );

    // Result of the current capture, merged with the accumulator.
    always_comb begin
        cap_r = {core_c, core_d};
        if (op_q == MASK) begin
            cap_r[OPW-1:64] = '0;
        end
        acc_base = clr_q ? '0 : accum_q;
        acc_new  = acc_q ? (acc_base ^ cap_r) : cap_r;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        clr_d      = clr_q;
        a_d        = a_q;
        b_d        = b_q;
        core_a_d   = core_a_q;
        core_b_d   = core_b_q;
        core_sel_d = core_sel_q;
        accum_d    = accum_q;
        rsp_d_n    = rsp_q;
        err_d      = err_q;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    acc_d = cmd_acc;
                    clr_d = cmd_acc_clr;
                    a_d   = cmd_a;
                    b_d   = cmd_b;
                    if (is_legal_op(cmd_op)) begin
                        state_d = StDrive;
                    end else begin
                        // Illegal opcodes never reach the core nor touch the accumulator.
                        rsp_d_n = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StDrive: begin
                core_a_d   = a_q;
                core_b_d   = b_q;
                core_sel_d = op_q;
                if (CORE_LAT > 1) begin
                    cnt_load = 1'b1;
                    state_d  = StWait;
                end else begin
                    state_d = StCapture;
                end
            end
            StWait: begin
                cnt_en = 1'b1;
                if (cnt_done) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                accum_d = acc_new;
                rsp_d_n = acc_new;
                err_d   = 1'b0;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    core_sel_d = IDLE_SEL;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= IDLE_SEL;
            acc_q      <= 1'b0;
            clr_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            core_a_q   <= '0;
            core_b_q   <= '0;
            core_sel_q <= IDLE_SEL;
            accum_q    <= '0;
            rsp_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            clr_q      <= clr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            core_a_q   <= core_a_d;
            core_b_q   <= core_b_d;
            core_sel_q <= core_sel_d;
            accum_q    <= accum_d;
            rsp_q      <= rsp_d_n;
            err_q      <= err_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);
    assign core_a    = core_a_q;
    assign core_b    = core_b_q;
    assign core_sel  = core_sel_q;
    assign rsp_c     = rsp_q[OPW-1:HALF];
    assign rsp_d     = rsp_q[HALF-1:0];
    assign rsp_err   = err_q;

endmodule
